// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: bundle of the writeback arbiter's producer, register-file
// and hazard-query signals.
//   master: ALU/load and mul/div producers, ID-stage query (drives the inputs)
//   slave : the arbiter (drives md_ready, RegWrite/WB_*, q_*_pend)
interface wb_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_dst;
  logic [DATA_W-1:0] md_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WB_DstReg;
  logic [DATA_W-1:0] WB_Data;
  logic [ADDR_W-1:0] q_rs;
  logic [ADDR_W-1:0] q_rt;
  logic              q_rs_pend;
  logic              q_rt_pend;

  modport master (
    output alu_valid, alu_dst, alu_data,
    output md_valid, md_dst, md_data,
    output q_rs, q_rt,
    input  md_ready, RegWrite, WB_DstReg, WB_Data, q_rs_pend, q_rt_pend
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  md_valid, md_dst, md_data,
    input  q_rs, q_rt,
    output md_ready, RegWrite, WB_DstReg, WB_Data, q_rs_pend, q_rt_pend
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: drives the register file's single write port from the
// ALU/load path (priority, never stalled) and a FIFO of multiply/divide results.
// Queued results superseded by a younger ALU write to the same register are
// killed and popped silently. Pending-write query for ID-stage hazard stalls.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   producer inputs, md_ready, registered RegWrite/WB_DstReg/
//                 WB_Data, combinational q_rs_pend/q_rt_pend
//   stall_cnt, kill_cnt  saturating 16-bit statistics, only when the macro
//                 WB_ARB_STATS_EN is defined
module wb_write_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         kill_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] dst_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  live_q;
  logic [DEPTH-1:0]  live_next;
  logic [DEPTH-1:0]  kill_mask;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic full;
  logic empty;
  logic alu_issue;
  logic push;
  logic pop;
  logic rs_hit;
  logic rt_hit;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign alu_issue = bus.alu_valid && (bus.alu_dst != '0);
  // Register 0 results are accepted but never stored.
  assign push      = bus.md_valid && !full && (bus.md_dst != '0);
  assign pop       = !alu_issue && !empty;

  // Ready reflects occupancy only, not a same-cycle pop.
  assign bus.md_ready  = !full;
  assign bus.q_rs_pend = rs_hit && (bus.q_rs != '0);
  assign bus.q_rt_pend = rt_hit && (bus.q_rt != '0);

  // Kill matches and pending-write lookups over live entries.
  always_comb begin
    kill_mask = '0;
    rs_hit    = 1'b0;
    rt_hit    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && alu_issue && (dst_q[i] == bus.alu_dst)) kill_mask[i] = 1'b1;
      if (live_q[i] && (dst_q[i] == bus.q_rs)) rs_hit = 1'b1;
      if (live_q[i] && (dst_q[i] == bus.q_rt)) rt_hit = 1'b1;
    end
  end

  // Live bits: kills first, popped slot cleared, new entry stored live.
  always_comb begin
    live_next = live_q & ~kill_mask;
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = 1'b1;
  end

  // Entry payload storage; needs no reset since live bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr]  <= bus.md_dst;
      data_q[wr_ptr] <= bus.md_data;
    end
  end

  // FIFO control and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      live_q        <= '0;
      bus.RegWrite  <= 1'b0;
      bus.WB_DstReg <= '0;
      bus.WB_Data   <= '0;
    end else begin
      live_q <= live_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (alu_issue) begin
        bus.RegWrite  <= 1'b1;
        bus.WB_DstReg <= bus.alu_dst;
        bus.WB_Data   <= bus.alu_data;
      end else if (pop && live_q[rd_ptr]) begin
        bus.RegWrite  <= 1'b1;
        bus.WB_DstReg <= dst_q[rd_ptr];
        bus.WB_Data   <= data_q[rd_ptr];
      end else begin
        bus.RegWrite  <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] kill_num;
  logic [16:0]      kill_sum;

  // Several entries may be killed by one ALU write.
  always_comb begin
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_mask[i]) kill_num = kill_num + CNT_W'(1);
    end
    kill_sum = {1'b0, kill_cnt} + 17'(kill_num);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (bus.md_valid && full && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule
